dsp_mac_sequencer: RTL and testbench

//  Sequences one DSP48E1 (MULTIPLY, ONE48, A/B/M/P regs = 1) as a streaming dot-product engine.

---
 rtl/dsp_mac_sequencer.sv | 157 +++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - dot-product sequencer driving one DSP48E1 multiply-accumulate slice
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_valid/s_ready           operand beat handshake
//   s_a, s_b                  signed operands for the current beat
//   s_bias                    signed bias, taken from the first beat of each vector
//   s_last                    marks the final beat of a vector
//   m_valid/m_ready           result handshake
//   m_result                  bias + sum(a*b) for one vector, wraps mod 2^48
//   m_len_err                 sticky flag: a vector hit MAX_LEN beats without s_last
//   dsp_a/b/c/opmode/ce/rst   DSP48E1 control and data pins
//   dsp_p                     DSP48E1 P output
module dsp_mac_sequencer #(
    parameter int A_W     = 25,
    parameter int B_W     = 18,
    parameter int LAT     = 3,
    parameter int MAX_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [A_W-1:0]        s_a,
    input  logic [B_W-1:0]        s_b,
    input  logic [47:0]           s_bias,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [47:0]           m_result,
    output logic                  m_len_err,
    output logic [29:0]           dsp_a,
    output logic [17:0]           dsp_b,
    output logic [47:0]           dsp_c,
    output logic [6:0]            dsp_opmode,
    output logic                  dsp_ce,
    output logic                  dsp_rst,
    input  logic [47:0]           dsp_p
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    localparam logic [6:0] OP_ZERO  = 7'b0000000;
    localparam logic [6:0] OP_MAC_C = 7'b0110101;
    localparam logic [6:0] OP_MAC_P = 7'b0100101;
    localparam logic [6:0] OP_HOLD  = 7'b0100000;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // Beat tracking pipe, one stage per DSP register level. first/bias are
    // only consumed at the adder stage, so they stop one stage short.
    logic [LAT-1:0]   pipe_vld;
    logic [LAT-1:0]   pipe_last;
    logic [LAT-2:0]   pipe_first;
    logic [47:0]      pipe_bias [LAT-1];

    logic             stall;
    logic             accept;
    logic             beat_first;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit_max;
    logic             beat_last;
    logic             capture;

    // Hold the whole DSP only when a finished sum sits in P and the previous
    // result has not been taken yet; otherwise P can keep accumulating.
    assign stall   = m_valid && !m_ready && pipe_vld[LAT-1] && pipe_last[LAT-1];
    assign dsp_ce  = run && !stall;
    assign s_ready = run && !stall;
    assign accept  = s_valid && s_ready;
    assign dsp_rst = rst;

    assign beat_first = (state == IDLE);
    assign cnt_inc    = beat_first ? CNT_W'(1) : cnt + CNT_W'(1);
    assign hit_max    = (cnt_inc == MAX_CNT);
    assign beat_last  = s_last || hit_max;
    assign capture    = dsp_ce && pipe_vld[LAT-1] && pipe_last[LAT-1];

    // The DSP A/B input registers are the first pipe stage, so operands go
    // straight to the pins; zero them on non-accepted cycles.
    assign dsp_a = accept ? 30'($signed(s_a)) : 30'd0;
    assign dsp_b = accept ? 18'($signed(s_b)) : 18'd0;

    // Adder stage: the beat whose product is in the M register picks the
    // accumulate source. A first beat restarts from C = bias.
    always_comb begin
        dsp_opmode = OP_ZERO;
        dsp_c      = 48'd0;
        if (run) begin
            if (pipe_vld[LAT-2]) begin
                if (pipe_first[LAT-2]) begin
                    dsp_opmode = OP_MAC_C;
                    dsp_c      = pipe_bias[LAT-2];
                end else begin
                    dsp_opmode = OP_MAC_P;
                end
            end else begin
                dsp_opmode = OP_HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            run       <= 1'b0;
            m_len_err <= 1'b0;
            m_valid   <= 1'b0;
            m_result  <= 48'd0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                cnt   <= cnt_inc;
                state <= beat_last ? IDLE : ACC;
                if (hit_max && !s_last) begin
                    m_len_err <= 1'b1;
                end
            end
            if (capture) begin
                m_result <= dsp_p;
                m_valid  <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld   <= '0;
            pipe_last  <= '0;
            pipe_first <= '0;
            for (int i = 0; i < LAT - 1; i++) begin
                pipe_bias[i] <= 48'd0;
            end
        end else if (dsp_ce) begin
            pipe_vld   <= {pipe_vld[LAT-2:0], accept};
            pipe_last  <= {pipe_last[LAT-2:0], accept && beat_last};
            for (int i = LAT - 2; i > 0; i--) begin
                pipe_first[i] <= pipe_first[i-1];
                pipe_bias[i]  <= pipe_bias[i-1];
            end
            pipe_first[0] <= accept && beat_first;
            pipe_bias[0]  <= (accept && beat_first) ? s_bias : 48'd0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - self-checking bench for dsp_mac_sequencer with a DSP48E1 behavioural model
module tb_dsp_mac_sequencer;

    localparam int A_W     = 25;
    localparam int B_W     = 18;
    localparam int LAT     = 3;
    localparam int MAX_LEN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [A_W-1:0]    s_a;
    logic [B_W-1:0]    s_b;
    logic [47:0]       s_bias;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [47:0]       m_result;
    logic              m_len_err;
    logic [29:0]       dsp_a;
    logic [17:0]       dsp_b;
    logic [47:0]       dsp_c;
    logic [6:0]        dsp_opmode;
    logic              dsp_ce;
    logic              dsp_rst;
    logic [47:0]       dsp_p;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .A_W(A_W), .B_W(B_W), .LAT(LAT), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .s_bias(s_bias), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
        .m_len_err(m_len_err),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
    );

    // DSP48E1 model: AREG=BREG=MREG=PREG=1, C and OPMODE unregistered.
    logic signed [29:0] areg;
    logic signed [17:0] breg;
    logic [47:0]        mreg;
    logic [47:0]        preg;
    logic [47:0]        xy_sel;
    logic [47:0]        z_sel;
    assign dsp_p = preg;

    always_comb begin
        xy_sel = (dsp_opmode[3:0] == 4'b0101) ? mreg : 48'd0;
        case (dsp_opmode[6:4])
            3'b010:  z_sel = preg;
            3'b011:  z_sel = dsp_c;
            default: z_sel = 48'd0;
        endcase
    end

    always @(posedge clk or posedge dsp_rst) begin
        if (dsp_rst) begin
            areg <= '0; breg <= '0; mreg <= '0; preg <= '0;
        end else if (dsp_ce) begin
            areg <= dsp_a;
            breg <= dsp_b;
            mreg <= $signed(48'(areg)) * $signed(48'(breg));
            preg <= z_sel + xy_sel;
        end
    end

    typedef struct {
        int                 n;
        logic [A_W-1:0]     a [3];
        logic [B_W-1:0]     b [3];
        logic [47:0]        bias;
        logic [47:0]        exp;
    } vec_t;

    vec_t        tbl [6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          drops = 0;
    int          w;
    int          bad;
    logic [47:0] res_q [$];
    int          res_cyc_q [$];
    int          acc_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                res_q.push_back(m_result);
                res_cyc_q.push_back(cyc);
            end
            if (s_valid && s_ready && s_last) acc_cyc_q.push_back(cyc);
            if (s_valid && !s_ready) drops++;
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int n,
                           input logic [A_W-1:0] a0, input logic [A_W-1:0] a1, input logic [A_W-1:0] a2,
                           input logic [B_W-1:0] b0, input logic [B_W-1:0] b1, input logic [B_W-1:0] b2,
                           input logic [47:0] bias, input logic [47:0] exp);
        tbl[idx].n = n;
        tbl[idx].a[0] = a0; tbl[idx].a[1] = a1; tbl[idx].a[2] = a2;
        tbl[idx].b[0] = b0; tbl[idx].b[1] = b1; tbl[idx].b[2] = b2;
        tbl[idx].bias = bias;
        tbl[idx].exp  = exp;
    endtask

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [47:0] bias, input logic last);
        int t;
        s_valid = 1'b1; s_a = a; s_b = b; s_bias = bias; s_last = last;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Non-first beats carry a junk bias that must be ignored.
    task automatic send_vec(input int idx);
        for (int j = 0; j < tbl[idx].n; j++) begin
            send(tbl[idx].a[j], tbl[idx].b[j], (j == 0) ? tbl[idx].bias : 48'hDEAD_0000_BEEF,
                 j == tbl[idx].n - 1);
        end
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (res_q.size() < n && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (res_q.size() < n) begin
            checks++; errors++;
            $display("FAIL result_timeout: got %0d results, required %0d", res_q.size(), n);
            while (res_q.size() < n) begin
                res_q.push_back('x);
                res_cyc_q.push_back(0);
            end
        end
    endtask

    task automatic clear_q();
        res_q.delete(); res_cyc_q.delete(); acc_cyc_q.delete();
    endtask

    initial begin
        set_vec(0, 3, 25'd1, 25'd2, 25'd3, 18'd4, 18'd5, 18'd6, 48'd10, 48'd42);
        set_vec(1, 1, -25'sd7, 25'd0, 25'd0, 18'd3, 18'd0, 18'd0, 48'd0, -48'sd21);
        set_vec(2, 1, 25'd2, 25'd0, 25'd0, 18'd2, 18'd0, 18'd0, 48'd1, 48'd5);
        set_vec(3, 1, 25'd1, 25'd0, 25'd0, 18'd1, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
        set_vec(4, 3, -25'sd3, 25'd100, 25'd5, -18'sd2, -18'sd1, 18'd0, -48'sd5, -48'sd99);
        set_vec(5, 2, 25'h100_0000, 25'h0FF_FFFF, 25'd0, 18'h2_0000, 18'h1_FFFF, 18'd0, 48'd0,
                48'h03FF_FEFE_0001);

        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_bias = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 48'(s_ready), 48'd0);
        chk("rst_m_valid", 48'(m_valid), 48'd0);
        chk("rst_m_result", m_result, 48'd0);
        chk("rst_m_len_err", 48'(m_len_err), 48'd0);
        chk("rst_dsp_ce", 48'(dsp_ce), 48'd0);
        chk("rst_dsp_opmode", 48'(dsp_opmode), 48'd0);
        chk("rst_dsp_a", 48'(dsp_a), 48'd0);
        chk("rst_dsp_b", 48'(dsp_b), 48'd0);
        chk("rst_dsp_c", dsp_c, 48'd0);
        chk("rst_dsp_rst", 48'(dsp_rst), 48'd1);

        @(posedge clk); #1;
        rst = 1'b0;
        chk("rel_s_ready_low", 48'(s_ready), 48'd0);
        @(posedge clk); #1;
        chk("rel_s_ready_high", 48'(s_ready), 48'd1);

        // Table: all vectors back to back with the consumer always ready.
        clear_q(); drops = 0;
        for (int i = 0; i < 6; i++) send_vec(i);
        wait_results(6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tbl%0d_result", i), res_q[i], tbl[i].exp);
            chk($sformatf("tbl%0d_latency", i), 48'(res_cyc_q[i] - acc_cyc_q[i]), 48'd4);
        end
        chk("tbl_no_s_ready_drop", 48'(drops), 48'd0);
        chk("t2_consecutive", 48'(res_cyc_q[2] - res_cyc_q[1]), 48'd1);

        // T3: consumer stalls with two vectors in flight.
        clear_q();
        m_ready = 1'b0;
        send(25'd1, 18'd1, 48'd0, 1'b0);
        send(25'd2, 18'd1, 48'hFFFF, 1'b1);
        send(25'd3, 18'd3, 48'd1, 1'b1);
        w = 0;
        while (!m_valid && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (2) @(posedge clk);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_result !== 48'd3 || dsp_ce !== 1'b0 || s_ready !== 1'b0) bad++;
        end
        chk("t3_hold_cycles_bad", 48'(bad), 48'd0);
        chk("t3_p_waiting", dsp_p, 48'd10);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_results(2);
        chk("t3_first", res_q[0], 48'd3);
        chk("t3_second", res_q[1], 48'd10);
        chk("t3_back_to_back", 48'(res_cyc_q[1] - res_cyc_q[0]), 48'd1);

        // T4: over-length vector split at MAX_LEN.
        clear_q();
        chk("t4_len_err_before", 48'(m_len_err), 48'd0);
        for (int k = 0; k < 6; k++) send(25'd1, 18'd1, 48'd0, k == 5);
        wait_results(2);
        chk("t4_first", res_q[0], 48'd4);
        chk("t4_second", res_q[1], 48'd2);
        chk("t4_len_err", 48'(m_len_err), 48'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_len_err_sticky", 48'(m_len_err), 48'd1);

        // T6: reset in the middle of a vector.
        send(25'd5, 18'd5, 48'd7, 1'b0);
        send(25'd5, 18'd5, 48'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_m_valid", 48'(m_valid), 48'd0);
        chk("t6_m_result", m_result, 48'd0);
        chk("t6_m_len_err", 48'(m_len_err), 48'd0);
        chk("t6_s_ready", 48'(s_ready), 48'd0);
        chk("t6_dsp_ce", 48'(dsp_ce), 48'd0);
        chk("t6_dsp_opmode", 48'(dsp_opmode), 48'd0);
        chk("t6_dsp_c", dsp_c, 48'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_q();
        send(25'd3, 18'd3, 48'd0, 1'b1);
        wait_results(1);
        chk("t6_result", res_q[0], 48'd9);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_single_result", 48'(res_q.size()), 48'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
